sprite_layer_mapper: RTL and testbench

Parametrised sprite mapper for the Contra renderer. Maps DrawX/DrawY onto one positioned, integer-scaled, optionally mirrored, multi-frame animated sprite held in an external synchronous ROM and palette. Emits RGB plus an opaque-pixel hit flag for the layer compositor. Replaces per-sprite full-screen stretch mappers.

---
 rtl/sprite_layer_mapper.sv | 99 +++++++++
 tb/tb_sprite_layer_mapper.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sprite_layer_mapper.sv
// sprite_layer_mapper: maps DrawX/DrawY onto one positioned, scaled, mirrored, animated ROM sprite
// Three-cycle pipeline: address -> ROM index -> palette colour and opaque hit
module sprite_layer_mapper #(
  parameter int SPR_W      = 40,
  parameter int SPR_H      = 66,
  parameter int FRAMES     = 4,
  parameter int SCALE_LOG2 = 1,
  parameter int HOLD       = 8,
  parameter int ADDR_W     = 14,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0,
  localparam int FW        = FRAMES > 1 ? $clog2(FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              flip_h,
  input  logic              anim_en,
  input  logic              frame_load,
  input  logic [FW-1:0]     frame_init,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hit
);
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
  localparam logic [10:0] BOX_W = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] BOX_H = 11'(SPR_H << SCALE_LOG2);
  localparam logic [ADDR_W-1:0] FSZ = ADDR_W'(SPR_W * SPR_H);
  logic [9:0] sx, sy;
  logic flip;
  logic [FW-1:0] frame, init_c;
  logic [HW-1:0] hold;
  logic v1, v2;
  logic frame_start, in_box, opaque;
  logic [10:0] dx, dy;
  logic [9:0] u_raw, u, v;
  logic [ADDR_W-1:0] addr;
  assign frame_start = DrawX == 10'd0 && DrawY == 10'd0;
  assign init_c = 32'(frame_init) >= FRAMES ? FW'(FRAMES - 1) : frame_init;
  // bit 10 of the 11-bit difference is the borrow: pixel lies left of / above the sprite
  assign dx = {1'b0, DrawX} - {1'b0, sx};
  assign dy = {1'b0, DrawY} - {1'b0, sy};
  assign in_box = !dx[10] && !dy[10] && dx < BOX_W && dy < BOX_H;
  assign u_raw = dx[9:0] >> SCALE_LOG2;
  assign v = dy[9:0] >> SCALE_LOG2;
  assign u = flip ? 10'(SPR_W - 1) - u_raw : u_raw;
  assign addr = ADDR_W'(frame) * FSZ + ADDR_W'(v) * ADDR_W'(SPR_W) + ADDR_W'(u);
  assign pal_index = rom_q;
  assign opaque = v2 && rom_q != IDX_W'(TRANSP_IDX);
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      sx <= '0;
      sy <= '0;
      flip <= 1'b0;
      frame <= '0;
      hold <= '0;
      rom_address <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      hit <= 1'b0;
      red <= '0;
      green <= '0;
      blue <= '0;
    end else begin
      if (frame_start) begin
        sx <= sprite_x;
        sy <= sprite_y;
        flip <= flip_h;
        if (frame_load) begin
          frame <= init_c;
          hold <= '0;
        end else if (anim_en) begin
          if (hold == HW'(HOLD - 1)) begin
            hold <= '0;
            frame <= frame == FW'(FRAMES - 1) ? '0 : frame + 1'b1;
          end else
            hold <= hold + 1'b1;
        end
      end
      rom_address <= in_box ? addr : '0;
      v1 <= in_box && blank;
      v2 <= v1;
      hit <= opaque;
      red <= opaque ? pal_red : 4'd0;
      green <= opaque ? pal_green : 4'd0;
      blue <= opaque ? pal_blue : 4'd0;
    end
endmodule

// File: tb/tb_sprite_layer_mapper.sv
// tb_sprite_layer_mapper: directed checks of placement, flip, transparency, animation and edges
// ROM returns rom_address[3:0] one cycle late; palette maps index 5 to F/8/2
module tb_sprite_layer_mapper;
  logic vga_clk = 1'b0, reset_n = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, sprite_x = '0, sprite_y = '0;
  logic blank = 1'b0, flip_h = 1'b0, anim_en = 1'b0, frame_load = 1'b0;
  logic [1:0] frame_init = '0;
  logic [13:0] rom_address;
  logic [3:0] rom_q = '0, pal_index, pal_red, pal_green, pal_blue, red, green, blue;
  logic hit;
  int n_checks = 0, n_errors = 0;

  sprite_layer_mapper dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .flip_h(flip_h), .anim_en(anim_en),
    .frame_load(frame_load), .frame_init(frame_init), .rom_address(rom_address),
    .rom_q(rom_q), .pal_index(pal_index), .pal_red(pal_red), .pal_green(pal_green),
    .pal_blue(pal_blue), .red(red), .green(green), .blue(blue), .hit(hit)
  );

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) rom_q <= rom_address[3:0];
  assign pal_red = pal_index == 4'd5 ? 4'hF : pal_index;
  assign pal_green = pal_index == 4'd5 ? 4'h8 : ~pal_index;
  assign pal_blue = pal_index == 4'd5 ? 4'h2 : pal_index ^ 4'h3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic b);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic frame_start();
    pix(0, 0, 1'b0);
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic b,
                       input int exp_addr, input logic exp_hit, input logic [11:0] exp_rgb);
    pix(x, y, b);
    check({tag, " addr"}, 32'(rom_address), 32'(exp_addr));
    pix(600, 600, 1'b0);
    pix(600, 600, 1'b0);
    check({tag, " hit"}, 32'(hit), 32'(exp_hit));
    check({tag, " rgb"}, {20'd0, red, green, blue}, {20'd0, exp_rgb});
  endtask

  initial begin
    DrawX = 10'd5;
    DrawY = 10'd5;
    blank = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1;
    check("reset hit", 32'(hit), 32'd0);
    check("reset rgb", {20'd0, red, green, blue}, 32'd0);
    check("reset addr", 32'(rom_address), 32'd0);
    reset_n = 1'b1;
    pix(10, 0, 1'b1);
    check("rel addr", 32'(rom_address), 32'd5);
    check("rel hit1", 32'(hit), 32'd0);
    pix(600, 600, 1'b0);
    check("rel hit2", 32'(hit), 32'd0);
    pix(600, 600, 1'b0);
    check("rel hit3", 32'(hit), 32'd1);
    check("rel rgb3", {20'd0, red, green, blue}, 32'hF82);

    sprite_x = 10'd100;
    sprite_y = 10'd50;
    frame_start();
    probe("tl", 100, 50, 1'b1, 0, 1'b0, 12'h000);
    probe("br", 179, 181, 1'b1, 2639, 1'b1, 12'hF0C);
    probe("mid", 110, 52, 1'b1, 45, 1'b1, 12'hD2E);
    probe("right", 180, 50, 1'b1, 0, 1'b0, 12'h000);
    probe("left", 99, 50, 1'b1, 0, 1'b0, 12'h000);
    probe("opq", 110, 50, 1'b1, 5, 1'b1, 12'hF82);
    probe("blank", 110, 50, 1'b0, 5, 1'b0, 12'h000);

    flip_h = 1'b1;
    frame_start();
    probe("flip", 100, 50, 1'b1, 39, 1'b1, 12'h784);
    sprite_x = 10'd200;
    probe("shadow", 100, 50, 1'b1, 39, 1'b1, 12'h784);
    probe("shadow new", 200, 50, 1'b1, 0, 1'b0, 12'h000);
    frame_start();
    probe("latched", 200, 50, 1'b1, 39, 1'b1, 12'h784);
    flip_h = 1'b0;
    sprite_x = 10'd100;

    anim_en = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      frame_start();
      pix(100, 50, 1'b1);
      check($sformatf("anim %0d", k), 32'(rom_address), 32'(((k / 8) % 4) * 2640));
    end
    anim_en = 1'b0;
    for (int k = 0; k < 10; k++) frame_start();
    pix(100, 50, 1'b1);
    check("frozen", 32'(rom_address), 32'd5280);
    frame_init = 2'd3;
    frame_load = 1'b1;
    pix(100, 50, 1'b1);
    check("load ignored", 32'(rom_address), 32'd5280);
    frame_start();
    frame_load = 1'b0;
    pix(100, 50, 1'b1);
    check("load", 32'(rom_address), 32'd7920);
    anim_en = 1'b1;
    for (int k = 0; k < 7; k++) frame_start();
    pix(100, 50, 1'b1);
    check("load hold0", 32'(rom_address), 32'd7920);
    frame_start();
    pix(100, 50, 1'b1);
    check("load wrap", 32'(rom_address), 32'd0);
    anim_en = 1'b0;

    sprite_x = 10'd1000;
    frame_start();
    probe("offscr", 1010, 50, 1'b1, 5, 1'b1, 12'hF82);
    probe("nowrap", 10, 50, 1'b1, 0, 1'b0, 12'h000);
    probe("nowrap0", 0, 51, 1'b1, 0, 1'b0, 12'h000);
    sprite_x = 10'd100;
    sprite_y = 10'd470;
    frame_start();
    probe("bottom", 110, 479, 1'b1, 165, 1'b1, 12'hF82);
    probe("above", 110, 469, 1'b1, 0, 1'b0, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
